// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard scheduler and its
// multi-cycle mult/div sequencer.
package hazard_sched_ctrl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         MUL_LAT_DEF = 4;
   localparam int         DIV_LAT_DEF = 32;
   localparam int         MD_CNT_W    = 6;

   // True when the ID instruction actually reads register r; $0 never matches.
   function automatic logic reg_match(input logic [4:0] r,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       use_rs,
                                      input logic       use_rt);
      return (r != REG_ZERO) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
   endfunction

endpackage

// File: rtl/hazard_sched_ctrl_muldiv_sequencer.sv
// Busy sequencer for the EX-stage mult/div unit: registers the issue into a
// start pulse, then counts the operation latency and flags the final cycle.
module muldiv_sequencer
   import hazard_sched_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_issue,
   input  logic i_isdiv,
   output logic o_md_start,
   output logic o_md_isdiv,
   output logic o_md_busy,
   output logic o_md_done
);

   // The start cycle is not counted as busy, so load latency minus one.
   localparam logic [MD_CNT_W-1:0] MUL_LD = MD_CNT_W'(MUL_LAT - 1);
   localparam logic [MD_CNT_W-1:0] DIV_LD = MD_CNT_W'(DIV_LAT - 1);

   md_state_e             r_state;
   md_state_e             w_state_nxt;
   logic [MD_CNT_W-1:0]   r_cnt;
   logic [MD_CNT_W-1:0]   w_cnt_nxt;
   logic                  r_start;
   logic                  r_isdiv;
   logic                  w_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_start <= 1'b0;
         r_isdiv <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_start <= i_issue;
         r_isdiv <= i_isdiv;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_start) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = r_isdiv ? DIV_LD : MUL_LD;
            end
         end
         BUSY: begin
            if (r_cnt == '0) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - MD_CNT_W'(1);
            end
         end
      endcase
   end

   assign o_md_start = r_start;
   assign o_md_isdiv = r_isdiv;
   assign o_md_busy  = (r_state == BUSY);
   assign o_md_done  = w_done;

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline with branches resolved in ID,
// including mult/div sequencing and a stall-cycle performance counter.
module hazard_sched_ctrl
   import hazard_sched_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_ID,
   input  logic [4:0]  rt_ID,
   input  logic        UseRs_ID,
   input  logic        UseRt_ID,
   input  logic        Branch_ID,
   input  logic        JrOp_ID,
   input  logic        Redirect_ID,
   input  logic        MulDiv_ID,
   input  logic        IsDiv_ID,
   input  logic        MfHiLo_ID,
   input  logic        RegWrite_EX,
   input  logic        MemRead_EX,
   input  logic [4:0]  Rw_EX,
   input  logic        MemRead_MEM,
   input  logic [4:0]  Rw_MEM,
   output logic        hold_PC,
   output logic        hold_IFID,
   output logic        flush_IFID,
   output logic        flush_IDEX,
   output logic        md_start,
   output logic        md_isdiv,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cnt
);

   logic        w_m_ex;
   logic        w_m_mem;
   logic        w_br_id;
   logic        w_load_use;
   logic        w_br_ex;
   logic        w_br_mem;
   logic        w_md_hz;
   logic        w_stall;
   logic        w_issue;
   logic [31:0] r_stall_cnt;

   assign w_m_ex  = reg_match(Rw_EX,  rs_ID, rt_ID, UseRs_ID, UseRt_ID);
   assign w_m_mem = reg_match(Rw_MEM, rs_ID, rt_ID, UseRs_ID, UseRt_ID);
   assign w_br_id = Branch_ID || JrOp_ID;

   // ID-resolved branches have no EX/MEM forwarding into the comparator,
   // so any in-flight producer stalls them; ordinary ops only stall on loads.
   assign w_load_use = MemRead_EX && w_m_ex;
   assign w_br_ex    = w_br_id && RegWrite_EX && w_m_ex;
   assign w_br_mem   = w_br_id && MemRead_MEM && w_m_mem;

   // md_start covers the gap cycle before the sequencer reports busy.
   assign w_md_hz = (MulDiv_ID || MfHiLo_ID) && (md_busy || md_start);

   assign w_stall = w_load_use || w_br_ex || w_br_mem || w_md_hz;
   assign w_issue = MulDiv_ID && !w_stall;

   assign hold_PC    = w_stall;
   assign hold_IFID  = w_stall;
   assign flush_IDEX = w_stall;
   assign flush_IFID = Redirect_ID && !w_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;

   muldiv_sequencer #(
      .MUL_LAT (MUL_LAT),
      .DIV_LAT (DIV_LAT)
   ) u_mdseq (
      .clk        (clk),
      .reset      (reset),
      .i_issue    (w_issue),
      .i_isdiv    (IsDiv_ID),
      .o_md_start (md_start),
      .o_md_isdiv (md_isdiv),
      .o_md_busy  (md_busy),
      .o_md_done  (md_done)
   );

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
Central stall/flush scheduler for the 5-stage MIPS pipeline with branches resolved in ID. It detects load-use and branch-operand hazards and generates the hold/flush controls for PC, IF/ID and ID/EX. It also sequences the multi-cycle MULT/DIV unit in EX through a busy FSM, and stalls dependent or conflicting instructions in ID until the unit completes. A 32-bit stall-cycle performance counter is included.

Parameters:
MUL_LAT, 4, cycles from md_start to md_done for MULT/MULTU (range 1..63)
DIV_LAT, 32, cycles from md_start to md_done for DIV/DIVU (range 1..63)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
rs_ID  input  5  rs field of instruction in ID
rt_ID  input  5  rt field of instruction in ID
UseRs_ID  input  1  ID instruction reads rs
UseRt_ID  input  1  ID instruction reads rt
Branch_ID  input  1  conditional branch in ID (compares rs/rt in ID)
JrOp_ID  input  1  jr/jalr in ID (reads rs in ID)
Redirect_ID  input  1  taken branch or any jump resolved in ID this cycle
MulDiv_ID  input  1  mult/multu/div/divu in ID
IsDiv_ID  input  1  qualifies MulDiv_ID: 1 = divide
MfHiLo_ID  input  1  mfhi/mflo in ID
RegWrite_EX  input  1  EX instruction writes a register
MemRead_EX  input  1  EX instruction is a load
Rw_EX  input  5  EX destination register
MemRead_MEM  input  1  MEM instruction is a load
Rw_MEM  input  5  MEM destination register
hold_PC  output  1  PC keeps its value
hold_IFID  output  1  IF/ID keeps its contents
flush_IFID  output  1  IF/ID loads a bubble
flush_IDEX  output  1  ID/EX loads a bubble
md_start  output  1  one-cycle pulse: mult/div unit latches its operands (instruction is in EX)
md_isdiv  output  1  operation select valid with md_start
md_busy  output  1  mult/div unit is computing
md_done  output  1  one-cycle pulse on the final busy cycle; HI/LO are valid from the next cycle
stall_cnt  output  32  count of cycles with stall asserted

Behaviour:
- Register match m(r) = (r != 0) && ((UseRs_ID && r == rs_ID) || (UseRt_ID && r == rt_ID)). Register $0 never matches.
- load_use = MemRead_EX && m(Rw_EX).
- br_ex = (Branch_ID || JrOp_ID) && RegWrite_EX && m(Rw_EX).
- br_mem = (Branch_ID || JrOp_ID) && MemRead_MEM && m(Rw_MEM).
- A branch that depends on a load therefore stalls 2 cycles: first via load_use/br_ex, then via br_mem.
- md_hz = (MulDiv_ID || MfHiLo_ID) && (state != IDLE || md_start).
- stall = load_use || br_ex || br_mem || md_hz. All of these terms are combinational.
- While stall is asserted: hold_PC = hold_IFID = flush_IDEX = 1.
- flush_IFID = Redirect_ID && !stall. Stall has priority over redirect; the redirect is re-evaluated after the stall ends.
- Issue: issue = MulDiv_ID && !stall. It is registered: md_start = issue delayed one cycle, and md_isdiv = IsDiv_ID delayed one cycle.
- FSM states: IDLE, BUSY.
  - IDLE -> BUSY when md_start = 1. The counter loads (IsDiv ? DIV_LAT : MUL_LAT) - 1.
  - In BUSY, the counter decrements each cycle.
  - When BUSY and counter == 0: md_done = 1, next state IDLE.
  - If a latency is 1: enter BUSY with counter 0; md_done asserts the cycle after md_start.
- md_busy = (state == BUSY).
- A mult/div or mfhi/mflo in ID stalls from its issue-plus-one cycle through the md_done cycle. It proceeds on the cycle after md_done.
- stall_cnt increments by 1 on every cycle with stall = 1, wrapping at 2^32-1 -> 0.
- Reset, including reset asserted mid-operation, applied on the next clk edge:
  - state = IDLE, counter = 0, md_start = md_isdiv = md_done = 0, stall_cnt = 0.
  - A pending operation is abandoned with no md_done.
  - The combinational hold/flush outputs still follow their inputs during reset.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE = 1'b0, BUSY = 1'b1).
  - REG_ZERO = 5'd0.
  - Default MUL_LAT/DIV_LAT constants.
  - Counter width MD_CNT_W = 6.
- One sub-module: muldiv_sequencer. It holds the FSM, counter, md_start/md_isdiv/md_done registers and md_busy.
- Hazard equations and stall_cnt stay in hazard_sched_ctrl.

Test Plan:
- Load-use: MemRead_EX = 1, Rw_EX = 8, UseRs_ID = 1, rs_ID = 8 -> hold_PC = hold_IFID = flush_IDEX = 1 for exactly 1 cycle; stall_cnt 0 -> 1. Repeat with Rw_EX = 0 -> no stall.
- Branch after load: Branch_ID = 1, rt_ID = 9, UseRt_ID = 1; lw $9 in EX then in MEM -> stall 2 consecutive cycles, then proceed.
- Redirect + stall collide: Redirect_ID = 1 while br_ex = 1 -> flush_IFID = 0 and hold asserted. Next cycle with no hazard -> flush_IFID = 1 for one cycle.
- Mult sequencing (MUL_LAT = 4): issue mult at cycle t -> md_start at t+1; md_busy at t+2..t+5; md_done at t+5. An mflo in ID from t+1 is held through t+5 and advances at t+6.
- Div back-to-back (DIV_LAT = 32): second div in ID stays stalled until md_done, then issues; md_start of the second follows the first's md_done by exactly 2 cycles.
- Reset mid-div: assert reset 10 cycles into BUSY -> next cycle md_busy = 0, no md_done ever, stall_cnt = 0.
